// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: instruction fetch stage in front of a combinational ROM.
// Owns the PC, captures ROM words into a one-entry IR and hands them to the
// decoder over valid/ready. Branch redirects squash the IR. The halt opcode
// 4'hF in the top nibble parks the unit until a restart or a redirect.
// Optional: define FETCH_PERF_EN to build the saturating fetch_count counter;
// without it, fetch_count is tied to zero.
module inst_fetch_unit #(
  parameter int unsigned   IW       = 9,
  parameter int unsigned   DW       = 32,
  parameter logic [IW-1:0] RESET_PC = '0
) (
  input  logic          CLK,
  input  logic          Reset,
  input  logic          start,
  output logic [IW-1:0] InstAddress,
  input  logic [DW-1:0] InstOut,
  input  logic          br_valid,
  input  logic [IW-1:0] br_target,
  output logic [DW-1:0] inst,
  output logic [IW-1:0] inst_pc,
  output logic          inst_valid,
  input  logic          inst_ready,
  output logic          done,
  output logic [15:0]   fetch_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_HALT
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] pc_q, pc_d;
  logic [DW-1:0] ir_q, ir_d;
  logic [IW-1:0] irpc_q, irpc_d;
  logic          valid_q, valid_d;
  logic          done_q, done_d;

  logic          adv;
  logic          is_halt;

  assign adv     = !valid_q || inst_ready;
  assign is_halt = (InstOut[DW-1 -: 4] == 4'hF);

  assign InstAddress = pc_q;
  assign inst        = ir_q;
  assign inst_pc     = irpc_q;
  assign inst_valid  = valid_q;
  assign done        = done_q;

  // Next-state logic: start restarts from any state, then redirect, then fetch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    irpc_d  = irpc_q;
    valid_d = valid_q;

    if (start) begin
      state_d = S_RUN;
      pc_d    = RESET_PC;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_IDLE;
        end
        S_RUN: begin
          if (br_valid) begin
            pc_d    = br_target;
            valid_d = 1'b0;
          end else if (adv) begin
            ir_d    = InstOut;
            irpc_d  = pc_q;
            valid_d = 1'b1;
            if (is_halt) begin
              state_d = S_HALT;
            end else begin
              pc_d = pc_q + IW'(1);
            end
          end
        end
        S_HALT: begin
          if (br_valid) begin
            state_d = S_RUN;
            pc_d    = br_target;
            valid_d = 1'b0;
          end else if (valid_q && inst_ready) begin
            valid_d = 1'b0;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    // done is a registered view of "halted with the IR drained", so it rises
    // the cycle after the halt word transfers and drops with any restart.
    done_d = (state_d == S_HALT) && !valid_d;
  end

  // State registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      irpc_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      irpc_q  <= irpc_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

`ifdef FETCH_PERF_EN
  logic [15:0] cnt_q;
  logic        fetch_cap;

  assign fetch_cap   = (state_q == S_RUN) && !start && !br_valid && adv;
  assign fetch_count = cnt_q;

  // Saturating count of IR captures, cleared on reset and on start.
  always_ff @(posedge CLK) begin
    if (Reset || start) begin
      cnt_q <= '0;
    end else if (fetch_cap && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end
`else
  assign fetch_count = '0;
`endif

endmodule
